// File: rtl/pt_axi4lite_pkg.sv
// Shared AXI4-Lite types for the register-interface initiator and the
// bridge responder: protocol field widths, response codes, FSM states.
package pt_axi4lite_pkg;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        IDLE,     // waiting for a request
        WR_REQ,   // AW and W outstanding
        WR_RSP,   // awaiting B
        RD_REQ,   // AR outstanding
        RD_RSP,   // awaiting R
        RESPOND   // holding the completion for the requester
    } initiator_state_t;

    // SLVERR and DECERR are failures; EXOKAY counts as success.
    function automatic logic resp_is_error(input logic [RESP_W-1:0] resp);
        return (axi_resp_t'(resp) == SLVERR) || (axi_resp_t'(resp) == DECERR);
    endfunction

endpackage

// File: rtl/pt_axi4lite_initiator.sv
// Single-outstanding AXI4-Lite master: turns one register-interface request
// into an AW+W/B or AR/R exchange and returns the completion on a
// valid/ready response stream.
module pt_axi4lite_initiator
    import pt_axi4lite_pkg::*;
#(
    parameter int                    AXI_ADDR_W = 32,
    parameter int                    RF_ADDR_W  = 32,
    parameter int                    DATA_W     = 64,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [PROT_W-1:0]     PROT       = 3'b000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    // request stream from the local agent
    input  logic [RF_ADDR_W-1:0]    i_req_address,
    input  logic [DATA_W-1:0]       i_req_wr_data,
    input  logic                    i_req_write,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,

    // completion stream back to the agent
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic                    o_rsp_error,
    output logic                    o_rsp_write,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,

    // AXI4-Lite write address
    output logic [AXI_ADDR_W-1:0]   o_awaddr,
    output logic [PROT_W-1:0]       o_awprot,
    output logic                    o_awvalid,
    input  logic                    i_awready,

    // AXI4-Lite write data
    output logic [DATA_W-1:0]       o_wdata,
    output logic [DATA_W/8-1:0]     o_wstrb,
    output logic                    o_wvalid,
    input  logic                    i_wready,

    // AXI4-Lite write response
    input  logic [RESP_W-1:0]       i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,

    // AXI4-Lite read address
    output logic [AXI_ADDR_W-1:0]   o_araddr,
    output logic [PROT_W-1:0]       o_arprot,
    output logic                    o_arvalid,
    input  logic                    i_arready,

    // AXI4-Lite read data
    input  logic [DATA_W-1:0]       i_rdata,
    input  logic [RESP_W-1:0]       i_rresp,
    input  logic                    i_rvalid,
    output logic                    o_rready
);

    initiator_state_t       state;
    initiator_state_t       state_nxt;

    logic [AXI_ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   aw_done;
    logic                   w_done;
    logic [DATA_W-1:0]      rsp_data_q;
    logic                   rsp_error_q;
    logic                   rsp_write_q;
    logic                   req_accept;

    assign req_accept = (state == IDLE) && i_req_valid;

    // State register; reset aborts any transaction straight back to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state is only ever assigned with <= so every
        // flop samples the pre-edge values of its neighbours.
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all handshake outputs, derived from the state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt   = state;
        o_req_ready = 1'b0;
        o_awvalid   = 1'b0;
        o_wvalid    = 1'b0;
        o_bready    = 1'b0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_rsp_valid = 1'b0;

        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_nxt = i_req_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                o_awvalid = !aw_done;
                o_wvalid  = !w_done;
                // A channel is finished if it completed earlier or its
                // ready is seen now while its valid is still up.
                if ((aw_done || i_awready) && (w_done || i_wready)) begin
                    state_nxt = WR_RSP;
                end
            end
            WR_RSP: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    state_nxt = RESPOND;
                end
            end
            RD_REQ: begin
                o_arvalid = 1'b1;
                if (i_arready) begin
                    state_nxt = RD_RSP;
                end
            end
            RD_RSP: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, per-channel write completion flags, response capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: these are plain registers with defined reset values;
            // clearing them here also discards any pending completion.
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            rsp_write_q <= 1'b0;
        end else begin
            if (req_accept) begin
                // Zero-extend, then offset; the sum wraps at AXI_ADDR_W bits.
                addr_q  <= AXI_ADDR_W'(i_req_address) + BASE_ADDR;
                wdata_q <= i_req_wr_data;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            if (state == WR_REQ) begin
                if (o_awvalid && i_awready) begin
                    aw_done <= 1'b1;
                end
                if (o_wvalid && i_wready) begin
                    w_done <= 1'b1;
                end
            end

            if ((state == WR_RSP) && i_bvalid) begin
                rsp_data_q  <= '0;
                rsp_error_q <= resp_is_error(i_bresp);
                rsp_write_q <= 1'b1;
            end

            if ((state == RD_RSP) && i_rvalid) begin
                rsp_data_q  <= i_rdata;
                rsp_error_q <= resp_is_error(i_rresp);
                rsp_write_q <= 1'b0;
            end
        end
    end

    // Address and data are held in registers, so they stay stable for as
    // long as the corresponding valid is up.
    assign o_awaddr    = addr_q;
    assign o_araddr    = addr_q;
    assign o_awprot    = PROT;
    assign o_arprot    = PROT;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = '1;

    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_error = rsp_error_q;
    assign o_rsp_write = rsp_write_q;

endmodule

// File: tb/tb_pt_axi4lite_initiator.sv
// Self-checking bench for pt_axi4lite_initiator: a configurable-delay AXI
// slave, a protocol monitor, a directed vector table, hand-written corner
// sequences (response back-pressure, reset mid-write) and random traffic
// checked against a transaction-level reference model.
module tb_pt_axi4lite_initiator;
    import pt_axi4lite_pkg::*;

    localparam int          TMO    = 60;
    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFF0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        axi_resp_t   resp;
        logic [63:0] rdata;
        int          aw_d;
        int          w_d;
        int          ar_d;
        int          rsp_d;
        logic [31:0] exp_addr;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic [31:0] req_address;
    logic [63:0] req_wr_data;
    logic        req_write;
    logic        req_valid;
    logic        rsp_ready;
    logic        awready, wready, arready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, rvalid;
    logic [63:0] rdata;

    // DUT A outputs (BASE_A)
    logic        a_req_ready, a_rsp_error, a_rsp_write, a_rsp_valid;
    logic [63:0] a_rsp_data, a_wdata;
    logic [31:0] a_awaddr, a_araddr;
    logic [2:0]  a_awprot, a_arprot;
    logic [7:0]  a_wstrb;
    logic        a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready;

    // DUT B outputs (BASE_B, wrapping offset)
    logic        b_req_ready, b_rsp_error, b_rsp_write, b_rsp_valid;
    logic [63:0] b_rsp_data, b_wdata;
    logic [31:0] b_awaddr, b_araddr;
    logic [2:0]  b_awprot, b_arprot;
    logic [7:0]  b_wstrb;
    logic        b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready;

    pt_axi4lite_initiator #(.BASE_ADDR(BASE_A)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_req_address(req_address), .i_req_wr_data(req_wr_data),
        .i_req_write(req_write), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .o_rsp_data(a_rsp_data), .o_rsp_error(a_rsp_error), .o_rsp_write(a_rsp_write),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_awaddr(a_awaddr), .o_awprot(a_awprot), .o_awvalid(a_awvalid), .i_awready(awready),
        .o_wdata(a_wdata), .o_wstrb(a_wstrb), .o_wvalid(a_wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(a_bready),
        .o_araddr(a_araddr), .o_arprot(a_arprot), .o_arvalid(a_arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(a_rready)
    );

    // Same stimulus, different base: runs in lockstep with dut_a.
    pt_axi4lite_initiator #(.BASE_ADDR(BASE_B)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req_address(req_address), .i_req_wr_data(req_wr_data),
        .i_req_write(req_write), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .o_rsp_data(b_rsp_data), .o_rsp_error(b_rsp_error), .o_rsp_write(b_rsp_write),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_awaddr(b_awaddr), .o_awprot(b_awprot), .o_awvalid(b_awvalid), .i_awready(awready),
        .o_wdata(b_wdata), .o_wstrb(b_wstrb), .o_wvalid(b_wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(b_bready),
        .o_araddr(b_araddr), .o_arprot(b_arprot), .o_arvalid(b_arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(b_rready)
    );

    int checks = 0;
    int errors = 0;

    // slave configuration for the current transaction
    int          cfg_aw_d, cfg_w_d, cfg_ar_d, cfg_rsp_d;
    axi_resp_t   cfg_resp;
    logic [63:0] cfg_rdata;

    // monitor results
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_hs_n = 0, r_hs_n = 0;
    int          proto_err = 0;
    logic        aw_got, w_got, ar_got;
    logic [31:0] mon_awaddr, mon_awaddr_b, mon_araddr, mon_araddr_b;
    logic [63:0] mon_wdata;
    logic [7:0]  mon_wstrb;
    logic        prev_aw, prev_w, prev_ar, prev_rsp;
    logic [31:0] prev_awaddr, prev_araddr;
    logic [63:0] prev_wdata, prev_rsp_data;
    logic        prev_rsp_err, prev_rsp_wr;

    // Protocol monitor: counts handshakes, records payloads, flags
    // unstable valids/payloads, early ready on B/R, and lockstep breaks.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            ar_got   <= 1'b0;
            prev_aw  <= 1'b0;
            prev_w   <= 1'b0;
            prev_ar  <= 1'b0;
            prev_rsp <= 1'b0;
        end else begin
            if ((a_bready && !(aw_got && w_got)) || (a_rready && !ar_got))
                proto_err <= proto_err + 1;
            if ((prev_aw && !(a_awvalid && a_awaddr == prev_awaddr)) ||
                (prev_w  && !(a_wvalid  && a_wdata  == prev_wdata))  ||
                (prev_ar && !(a_arvalid && a_araddr == prev_araddr)) ||
                (prev_rsp && !(a_rsp_valid && a_rsp_data == prev_rsp_data &&
                               a_rsp_error == prev_rsp_err && a_rsp_write == prev_rsp_wr)))
                proto_err <= proto_err + 1;
            if (b_awvalid !== a_awvalid || b_wvalid !== a_wvalid ||
                b_arvalid !== a_arvalid || b_rsp_valid !== a_rsp_valid)
                proto_err <= proto_err + 1;

            if (a_awvalid && awready) begin
                aw_hs_n      <= aw_hs_n + 1;
                aw_got       <= 1'b1;
                mon_awaddr   <= a_awaddr;
                mon_awaddr_b <= b_awaddr;
            end
            if (a_wvalid && wready) begin
                w_hs_n    <= w_hs_n + 1;
                w_got     <= 1'b1;
                mon_wdata <= a_wdata;
                mon_wstrb <= a_wstrb;
            end
            if (a_arvalid && arready) begin
                ar_hs_n      <= ar_hs_n + 1;
                ar_got       <= 1'b1;
                mon_araddr   <= a_araddr;
                mon_araddr_b <= b_araddr;
            end
            if (bvalid && a_bready) begin
                b_hs_n <= b_hs_n + 1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (rvalid && a_rready) begin
                r_hs_n <= r_hs_n + 1;
                ar_got <= 1'b0;
            end

            prev_aw       <= a_awvalid && !awready;
            prev_w        <= a_wvalid && !wready;
            prev_ar       <= a_arvalid && !arready;
            prev_rsp      <= a_rsp_valid && !rsp_ready;
            prev_awaddr   <= a_awaddr;
            prev_wdata    <= a_wdata;
            prev_araddr   <= a_araddr;
            prev_rsp_data <= a_rsp_data;
            prev_rsp_err  <= a_rsp_error;
            prev_rsp_wr   <= a_rsp_write;
        end
    end

    // AXI slave: readies after a per-channel wait, B only once AW and W are
    // both done, R only after AR, each response after cfg_rsp_d cycles.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c, seen_b, seen_r;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; seen_b = 0; seen_r = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0;
                bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                seen_b = b_hs_n; seen_r = r_hs_n;
            end else begin
                if (a_awvalid) begin awready = (aw_c >= cfg_aw_d); aw_c++; end
                else begin awready = 0; aw_c = 0; end
                if (a_wvalid) begin wready = (w_c >= cfg_w_d); w_c++; end
                else begin wready = 0; w_c = 0; end
                if (a_arvalid) begin arready = (ar_c >= cfg_ar_d); ar_c++; end
                else begin arready = 0; ar_c = 0; end

                if (bvalid && b_hs_n != seen_b) begin bvalid = 0; bresp = 0; seen_b = b_hs_n; end
                if (!bvalid && aw_got && w_got) begin
                    if (b_c >= cfg_rsp_d) begin bvalid = 1; bresp = cfg_resp; b_c = 0; end
                    else b_c++;
                end
                if (rvalid && r_hs_n != seen_r) begin rvalid = 0; rresp = 0; rdata = 0; seen_r = r_hs_n; end
                if (!rvalid && ar_got) begin
                    if (r_c >= cfg_rsp_d) begin rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata; r_c = 0; end
                    else r_c++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_req(input bit wr, input logic [31:0] a, input logic [63:0] d);
        int n;
        req_write = wr; req_address = a; req_wr_data = d; req_valid = 1'b1;
        n = 0;
        while (!a_req_ready && n < TMO) begin @(negedge clk); n++; end
        check("req_accept_in_time", 64'(n < TMO), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycles from the accept cycle (0) to the first cycle with rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!a_rsp_valid && lat < TMO) begin @(negedge clk); lat++; end
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int aw0, w0, ar0, b0, r0, p0, lat;
        logic [31:0] exp_b;
        aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n; b0 = b_hs_n; r0 = r_hs_n; p0 = proto_err;
        exp_b = v.addr + BASE_B;
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_ar_d = v.ar_d; cfg_rsp_d = v.rsp_d;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        send_req(v.wr, v.addr, v.wdata);
        wait_rsp(lat);
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_rsp_data"}, a_rsp_data, v.exp_data);
        check({tag, "_rsp_error"}, 64'(a_rsp_error), 64'(v.exp_err));
        check({tag, "_rsp_write"}, 64'(a_rsp_write), 64'(v.wr));
        if (v.wr) begin
            check({tag, "_awaddr"}, 64'(mon_awaddr), 64'(v.exp_addr));
            check({tag, "_awaddr_wrapbase"}, 64'(mon_awaddr_b), 64'(exp_b));
            check({tag, "_wdata"}, mon_wdata, v.wdata);
            check({tag, "_wstrb"}, 64'(mon_wstrb), 64'hFF);
        end else begin
            check({tag, "_araddr"}, 64'(mon_araddr), 64'(v.exp_addr));
            check({tag, "_araddr_wrapbase"}, 64'(mon_araddr_b), 64'(exp_b));
        end
        consume_rsp();
        check({tag, "_aw_count"}, 64'(aw_hs_n - aw0), 64'(v.wr ? 1 : 0));
        check({tag, "_w_count"}, 64'(w_hs_n - w0), 64'(v.wr ? 1 : 0));
        check({tag, "_b_count"}, 64'(b_hs_n - b0), 64'(v.wr ? 1 : 0));
        check({tag, "_ar_count"}, 64'(ar_hs_n - ar0), 64'(v.wr ? 0 : 1));
        check({tag, "_r_count"}, 64'(r_hs_n - r0), 64'(v.wr ? 0 : 1));
        check({tag, "_protocol"}, 64'(proto_err - p0), 64'd0);
        check({tag, "_ready_after"}, 64'(a_req_ready), 64'd1);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   n, p0, lat;

        vecs[0] = '{1'b1, 32'h10, 64'hDEAD_BEEF, OKAY, 64'h0, 0, 0, 0, 0, 32'h1010, 64'h0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h20, 64'h0, SLVERR, 64'h1234, 0, 0, 0, 0, 32'h1020, 64'h1234, 1'b1, 3};
        vecs[2] = '{1'b1, 32'h30, 64'h0123_4567_89AB_CDEF, OKAY, 64'h0, 3, 0, 0, 0, 32'h1030, 64'h0, 1'b0, 6};
        vecs[3] = '{1'b1, 32'h38, 64'hFEDC_BA98_7654_3210, DECERR, 64'h0, 0, 3, 0, 0, 32'h1038, 64'h0, 1'b1, 6};
        vecs[4] = '{1'b1, 32'h40, 64'h5555_AAAA_5555_AAAA, EXOKAY, 64'h0, 2, 2, 0, 0, 32'h1040, 64'h0, 1'b0, 5};
        vecs[5] = '{1'b0, 32'h48, 64'h0, EXOKAY, 64'hCAFE_F00D_0000_0001, 0, 0, 1, 2, 32'h1048, 64'hCAFE_F00D_0000_0001, 1'b0, 6};
        vecs[6] = '{1'b0, 32'hFFFF_FFF8, 64'h0, DECERR, 64'h77, 0, 0, 0, 1, 32'h0000_0FF8, 64'h77, 1'b1, 4};
        vecs[7] = '{1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, OKAY, 64'h0, 1, 0, 0, 3, 32'h1000, 64'h0, 1'b0, 7};

        rst = 1'b1; req_valid = 0; req_write = 0; req_address = 0; req_wr_data = 0; rsp_ready = 0;
        cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_rsp_d = 0; cfg_resp = OKAY; cfg_rdata = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("reset_req_ready", 64'(a_req_ready), 64'd1);
        check("reset_valids", 64'({a_awvalid, a_wvalid, a_arvalid, a_rsp_valid}), 64'd0);
        check("reset_readies", 64'({a_bready, a_rready}), 64'd0);
        check("reset_rsp_data", a_rsp_data, 64'd0);
        check("reset_awaddr", 64'(a_awaddr), 64'd0);
        check("reset_wdata", a_wdata, 64'd0);
        check("reset_prot", 64'({a_awprot, a_arprot}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // back-pressure on the response with a second request waiting
        cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_rsp_d = 0; cfg_resp = SLVERR; cfg_rdata = 64'h0BAD_0BAD;
        p0 = proto_err;
        send_req(1'b1, 32'h50, 64'h1111_2222);
        wait_rsp(lat);
        check("hold_first_rsp_valid", 64'(a_rsp_valid), 64'd1);
        req_write = 1'b0; req_address = 32'h58; req_wr_data = 64'h0; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold_c%0d_req_ready", c), 64'(a_req_ready), 64'd0);
            check($sformatf("hold_c%0d_rsp", c), 64'({a_rsp_valid, a_rsp_write, a_rsp_error}), 64'b111);
            check($sformatf("hold_c%0d_data", c), a_rsp_data, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_ready_after_hs", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold_second_accepted", 64'(a_arvalid), 64'd1);
        check("hold_second_araddr", 64'(a_araddr), 64'h1058);
        wait_rsp(lat);
        check("hold_second_data", a_rsp_data, 64'h0BAD_0BAD);
        check("hold_second_error", 64'(a_rsp_error), 64'd1);
        consume_rsp();
        check("hold_protocol", 64'(proto_err - p0), 64'd0);

        // reset while waiting for B
        cfg_resp = OKAY; cfg_rsp_d = 8;
        send_req(1'b1, 32'h60, 64'h9999);
        n = 0;
        while (!a_bready && n < TMO) begin @(negedge clk); n++; end
        check("rst_reached_wr_rsp", 64'(a_bready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valids", 64'({a_awvalid, a_wvalid, a_arvalid, a_rsp_valid}), 64'd0);
        check("rst_readies", 64'({a_bready, a_rready}), 64'd0);
        check("rst_req_ready", 64'(a_req_ready), 64'd1);
        v = '{1'b0, 32'h68, 64'h0, OKAY, 64'h1357_9BDF, 0, 0, 0, 0, 32'h1068, 64'h1357_9BDF, 1'b0, 3};
        do_txn(v, "post_rst");

        // random traffic against the transaction-level model
        for (int i = 0; i < 24; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = {$urandom, $urandom};
            v.resp  = axi_resp_t'($urandom_range(0, 3));
            v.rdata = {$urandom, $urandom};
            v.aw_d  = $urandom_range(0, 3);
            v.w_d   = $urandom_range(0, 3);
            v.ar_d  = $urandom_range(0, 3);
            v.rsp_d = $urandom_range(0, 3);
            v.exp_addr = v.addr + BASE_A;
            v.exp_data = v.wr ? 64'd0 : v.rdata;
            v.exp_err  = (v.resp == SLVERR) || (v.resp == DECERR);
            v.exp_lat  = 3 + v.rsp_d + (v.wr ? ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) : v.ar_d);
            do_txn(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pt_axi4lite_initiator.md
Name: pt_axi4lite_initiator

Overview:
- Converts single-beat register-interface requests from a local agent into AXI4-Lite master transactions.
- Returns the completion (read data, error flag) on a valid/ready response stream.
- Sits at the upstream end of an AXI4-Lite fabric and drives packtype-generated register files behind an AXI4-Lite responder.
- Strictly one outstanding transaction; no reordering.

Parameters:
- AXI_ADDR_W, 32: AXI address width; must be >= RF_ADDR_W.
- RF_ADDR_W, 32: request address width.
- DATA_W, 64: data width; multiple of 8.
- BASE_ADDR, 0: AXI_ADDR_W-bit offset added to every request address.
- PROT, 3'b000: constant driven on awprot/arprot.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req_address  in  RF_ADDR_W  request address
- i_req_wr_data  in  DATA_W  write data
- i_req_write  in  1  1=write, 0=read
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&&ready
- o_rsp_data  out  DATA_W  read data (0 for writes)
- o_rsp_error  out  1  response was SLVERR/DECERR
- o_rsp_write  out  1  response belongs to a write
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed
- o_awaddr  out  AXI_ADDR_W;  o_awprot  out  3;  o_awvalid  out  1;  i_awready  in  1
- o_wdata  out  DATA_W;  o_wstrb  out  DATA_W/8;  o_wvalid  out  1;  i_wready  in  1
- i_bresp  in  2;  i_bvalid  in  1;  o_bready  out  1
- o_araddr  out  AXI_ADDR_W;  o_arprot  out  3;  o_arvalid  out  1;  i_arready  in  1
- i_rdata  in  DATA_W;  i_rresp  in  2;  i_rvalid  in  1;  o_rready  out  1

Behaviour:
- Reset values: state IDLE; all valids, o_bready and o_rready 0; o_req_ready 1; address, data and response registers 0.
- States:
  - IDLE
  - WR_REQ: AW and W outstanding
  - WR_RSP: awaiting B
  - RD_REQ: AR outstanding
  - RD_RSP: awaiting R
  - RESPOND: holding the response
- o_req_ready = (state==IDLE). On acceptance, register address+BASE_ADDR (zero-extend, wrap modulo 2^AXI_ADDR_W) and data.
  - Write: go to WR_REQ.
  - Read: go to RD_REQ.
- WR_REQ:
  - o_awvalid and o_wvalid assert the cycle after acceptance.
  - Each valid drops independently after its own handshake. AW and W may complete in either order or in the same cycle.
  - Leave for WR_RSP when both are complete. A per-channel "done" flag is held for this.
  - Addr/data are stable while valid is high.
- o_wstrb: all ones.
- WR_RSP: o_bready=1. On bvalid, capture error=(bresp[1]), data=0, write=1, then go to RESPOND.
- RD_REQ: o_arvalid=1 until arready, then go to RD_RSP.
- RD_RSP: o_rready=1. On rvalid, capture rdata and error=(rresp[1]), write=0, then go to RESPOND.
- RESPOND: o_rsp_valid=1, outputs stable until i_rsp_ready. On handshake go to IDLE; the next request is accepted the following cycle.
- Minimum latency, request accept to o_rsp_valid, assuming a zero-wait slave:
  - Accept at cycle 0.
  - AW/W (or AR) handshake at cycle 1.
  - B/R handshake at cycle 2.
  - o_rsp_valid at cycle 3.
- EXOKAY is treated as OK.
- bvalid/rvalid arriving in any other state is ignored: ready is low, so it is not consumed.
- A request presented while busy stalls; the requester must hold it stable.
- Reset mid-transaction aborts immediately to IDLE, all valids low, and any pending response is discarded. The AXI slave must be reset by the same i_rst.

Decomposition:
- pt_axi4lite_pkg holds:
  - PROT_W=3, RESP_W=2.
  - axi_resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - The state enum.
- Shared with the bridge responder, which migrates its local enum to the package.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Write addr 0x10, data 0xDEAD_BEEF, BASE_ADDR 0x1000, zero-wait slave, BRESP OKAY -> awaddr 0x1010, wstrb 0xFF, response {write=1,error=0} at cycle 3.
- Read addr 0x20, slave returns 0x1234 with SLVERR -> araddr correct, response {data=0x1234,error=1,write=0}.
- Write where awready is delayed 3 cycles and wready is immediate (then the reverse, then both together) -> exactly one AW and one W handshake each, no B before both complete, single response.
- Hold i_rsp_ready=0 for 5 cycles with a second request pending -> o_req_ready stays 0, response held stable, second request accepted the cycle after the response handshake.
- Assert i_rst during WR_RSP -> all valids 0 and o_req_ready=1 the cycle after reset; a fresh read completes normally.
- Address wrap: BASE_ADDR 0xFFFF_FFF0, addr 0x20 -> araddr 0x0000_0010.
